// File: rtl/ads_multi_rx.sv
// ads_multi_rx: multi-lane ADS1675-style serial receiver; NCH DOUT lanes share one SCLK/DRDY
// pair, oversampled in clk, with completed frames presented on a valid/ready stream.
module ads_multi_rx #(
  parameter int DW          = 24,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit SAMPLE_FALL = 1'b1,
  parameter bit DRDY_ACT_HI = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sclk,
  input  logic              drdy,
  input  logic [NCH-1:0]    dout,
  output logic [NCH*DW-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_status
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0]          r_sclk_s, r_drdy_s;
  logic [SYNC_STAGES-1:0][NCH-1:0] r_dout_s;
  logic                            r_sclk_d, r_drdy_d;
  logic [CW-1:0]                   r_cnt;
  logic [NCH-1:0][DW-1:0]          r_shift;
  logic [NCH*DW-1:0]               r_data;
  logic                            r_valid, r_ovr, r_ferr;
  logic [15:0]                     r_fcnt;
  logic                            w_sclk, w_drdy, w_sample, w_start;
  logic                            w_restart, w_shift_en, w_load, w_drop;
  logic [NCH-1:0]                  w_dout;
  assign w_sclk   = r_sclk_s[SYNC_STAGES-1];
  assign w_drdy   = r_drdy_s[SYNC_STAGES-1];
  assign w_dout   = r_dout_s[SYNC_STAGES-1];
  assign w_sample = SAMPLE_FALL ? (r_sclk_d & ~w_sclk) : (~r_sclk_d & w_sclk);
  assign w_start  = DRDY_ACT_HI ? (~r_drdy_d & w_drdy) : (r_drdy_d & ~w_drdy);
  // a start edge beats a coincident sample edge, so that sample is simply dropped
  assign w_restart  = en && w_start && r_state != S_DONE;
  assign w_shift_en = en && !w_start && w_sample && r_state == S_SHIFT;
  assign w_load     = r_state == S_DONE && (!r_valid || m_ready);
  assign w_drop     = r_state == S_DONE && r_valid && !m_ready;
  always_comb begin
    w_next = r_state;
    w_next = !en ? S_IDLE : w_restart ? S_SHIFT : r_state == S_DONE ? S_IDLE :
             (w_shift_en && r_cnt == LAST) ? S_DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_drdy_s <= '0;
      r_dout_s <= '0;
      r_sclk_d <= 1'b0;
      r_drdy_d <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_fcnt   <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_drdy_s <= {r_drdy_s[SYNC_STAGES-2:0], drdy};
      r_dout_s <= {r_dout_s[SYNC_STAGES-2:0], dout};
      r_sclk_d <= w_sclk;
      r_drdy_d <= w_drdy;
      if (w_restart || !en) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < NCH; k++) r_shift[k] <= {r_shift[k][DW-2:0], w_dout[k]};
      end
      // a reload in the transfer cycle keeps m_valid high with no bubble
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_fcnt  <= r_fcnt + 16'd1;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
      r_ovr  <= w_drop | (r_ovr & ~clr_status);
      r_ferr <= (w_restart && r_state == S_SHIFT) | (r_ferr & ~clr_status);
    end
  end
  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign frame_cnt = r_fcnt;
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_ads_multi_rx.sv
// tb_ads_multi_rx: drives ADC-style frames on four lanes and checks the output stream against
// the frames sent, plus status flags, latency and handshake behaviour.
module tb_ads_multi_rx;
  localparam int DW = 24, NCH = 4, SS = 2, HALF = 4, W = NCH * DW;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, sclk = 1'b0, drdy = 1'b0, m_ready = 1'b0, clr_status = 1'b0;
  logic [NCH-1:0] dout = '0;
  logic [W-1:0] m_data;
  logic m_valid, overrun, frame_err;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_pass = 0, hold_bad = 0;
  logic [W-1:0] rx_q[$];
  logic p_v = 1'b0, p_r = 1'b0;
  logic [W-1:0] p_d = '0;

  ads_multi_rx #(.DW(DW), .NCH(NCH), .SYNC_STAGES(SS), .SAMPLE_FALL(1'b1), .DRDY_ACT_HI(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .sclk(sclk), .drdy(drdy), .dout(dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .frame_cnt(frame_cnt),
    .overrun(overrun), .frame_err(frame_err), .clr_status(clr_status));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) rx_q.push_back(m_data);
    if (!rst && p_v && !p_r && m_data !== p_d) hold_bad++;
    p_v = m_valid; p_r = m_ready; p_d = m_data;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rx_at(input int i);
    return i < rx_q.size() ? rx_q[i] : 'x;
  endfunction

  function automatic logic [W-1:0] rnd_frame();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset(input logic mr);
    rst = 1'b1; en = 1'b1; sclk = 1'b0; drdy = 1'b0; dout = '0; clr_status = 1'b0; m_ready = mr;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic adc_start();
    drdy = 1'b1;
    tick(HALF);
    drdy = 1'b0;
    tick(HALF);
  endtask

  // bits go out MSB first; dout changes with sclk rising, DUT samples on the falling edge
  task automatic adc_bits(input logic [W-1:0] f, input int from, input int to);
    for (int i = from; i < to; i++) begin
      sclk = 1'b1;
      for (int k = 0; k < NCH; k++) dout[k] = f[k*DW + DW-1-i];
      tick(HALF);
      sclk = 1'b0;
      if (i != to - 1) tick(HALF);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 20) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1;
    tick(3);
    n_chk++; if (m_data !== '0) $display("FAIL reset_data got %h want 0", m_data); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_directed();
    logic [DW-1:0] lanes [NCH];
    logic [W-1:0] f;
    int base, lat;
    lanes[0] = 24'h000001; lanes[1] = 24'h800000; lanes[2] = 24'h7FFFFF; lanes[3] = 24'hA5A5A5;
    for (int k = 0; k < NCH; k++) f[k*DW +: DW] = lanes[k];
    do_reset(1'b1);
    base = rx_q.size();
    adc_start();
    adc_bits(f, 0, DW);
    wait_valid(lat);
    n_chk++; if (lat !== SS + 2) $display("FAIL latency got %0d want %0d", lat, SS + 2); else n_pass++;
    tick(1);
    n_chk++; if (m_valid !== 1'b0) $display("FAIL single_pulse got %b want 0", m_valid); else n_pass++;
    tick(4);
    n_chk++; if (rx_q.size() - base !== 1) $display("FAIL dir_count got %0d want 1", rx_q.size() - base); else n_pass++;
    for (int k = 0; k < NCH; k++) begin
      logic [W-1:0] g;
      g = rx_at(base);
      n_chk++; if (g[k*DW +: DW] !== lanes[k]) $display("FAIL dir_lane%0d got %h want %h", k, g[k*DW +: DW], lanes[k]); else n_pass++;
    end
    n_chk++; if (frame_cnt !== 16'd1) $display("FAIL dir_cnt got %0d want 1", frame_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    int base;
    do_reset(1'b1);
    base = rx_q.size();
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] f;
      f = rnd_frame();
      exp_q.push_back(f);
      adc_start();
      adc_bits(f, 0, DW);
      tick(8);
    end
    tick(8);
    n_chk++; if (rx_q.size() - base !== 100) $display("FAIL rnd_count got %0d want 100", rx_q.size() - base); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      n_chk++; if (rx_at(base + i) !== exp_q[i]) $display("FAIL rnd_frame%0d got %h want %h", i, rx_at(base + i), exp_q[i]); else n_pass++;
    end
    n_chk++; if (frame_cnt !== 16'd100) $display("FAIL rnd_cnt got %0d want 100", frame_cnt); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL rnd_overrun got %b want 0", overrun); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL rnd_ferr got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [W-1:0] fa, fb;
    int base, hb;
    fa = rnd_frame(); fb = rnd_frame();
    do_reset(1'b0);
    base = rx_q.size();
    adc_start(); adc_bits(fa, 0, DW); tick(10);
    hb = hold_bad;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL ovr_validA got %b want 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== fa) $display("FAIL ovr_dataA got %h want %h", m_data, fa); else n_pass++;
    adc_start(); adc_bits(fb, 0, DW); tick(10);
    n_chk++; if (m_data !== fa) $display("FAIL ovr_hold got %h want %h", m_data, fa); else n_pass++;
    n_chk++; if (hold_bad - hb !== 0) $display("FAIL ovr_stable got %0d changes want 0", hold_bad - hb); else n_pass++;
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd1) $display("FAIL ovr_cnt got %0d want 1", frame_cnt); else n_pass++;
    m_ready = 1'b1;
    tick(3);
    n_chk++; if (rx_q.size() - base !== 1) $display("FAIL ovr_count got %0d want 1", rx_q.size() - base); else n_pass++;
    n_chk++; if (rx_at(base) !== fa) $display("FAIL ovr_out got %h want %h", rx_at(base), fa); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL ovr_drain got %b want 0", m_valid); else n_pass++;
    clr_status = 1'b1; tick(1); clr_status = 1'b0; tick(1);
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [W-1:0] fp, ff;
    int base;
    fp = rnd_frame(); ff = rnd_frame();
    do_reset(1'b1);
    base = rx_q.size();
    adc_start(); adc_bits(fp, 0, 10); tick(HALF);
    adc_start(); adc_bits(ff, 0, DW); tick(12);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL ferr_flag got %b want 1", frame_err); else n_pass++;
    n_chk++; if (rx_q.size() - base !== 1) $display("FAIL ferr_count got %0d want 1", rx_q.size() - base); else n_pass++;
    n_chk++; if (rx_at(base) !== ff) $display("FAIL ferr_frame got %h want %h", rx_at(base), ff); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd1) $display("FAIL ferr_cnt got %0d want 1", frame_cnt); else n_pass++;
    clr_status = 1'b1; tick(1); clr_status = 1'b0; tick(1);
    n_chk++; if (frame_err !== 1'b0) $display("FAIL ferr_clear got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fa, fb;
    int base;
    fa = rnd_frame(); fb = rnd_frame();
    do_reset(1'b0);
    base = rx_q.size();
    adc_start(); adc_bits(fa, 0, DW); tick(10);
    adc_start(); adc_bits(fb, 0, DW);
    tick(SS + 1);
    n_chk++; if (m_data !== fa) $display("FAIL b2b_before got %h want %h", m_data, fa); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    n_chk++; if (m_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== fb) $display("FAIL b2b_data got %h want %h", m_data, fb); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd2) $display("FAIL b2b_cnt got %0d want 2", frame_cnt); else n_pass++;
    tick(2);
    n_chk++; if (rx_q.size() - base !== 2) $display("FAIL b2b_count got %0d want 2", rx_q.size() - base); else n_pass++;
    n_chk++; if (rx_at(base) !== fa) $display("FAIL b2b_first got %h want %h", rx_at(base), fa); else n_pass++;
    n_chk++; if (rx_at(base + 1) !== fb) $display("FAIL b2b_second got %h want %h", rx_at(base + 1), fb); else n_pass++;
  endtask

  task automatic test_abort(input bit use_rst);
    logic [W-1:0] f1, f2;
    int base;
    f1 = rnd_frame(); f2 = rnd_frame();
    do_reset(1'b1);
    base = rx_q.size();
    adc_start(); adc_bits(f1, 0, 12);
    if (use_rst) rst = 1'b1; else en = 1'b0;
    tick(2);
    rst = 1'b0; en = 1'b1;
    tick(HALF);
    adc_bits(f1, 12, DW); tick(12);
    n_chk++; if (rx_q.size() - base !== 0) $display("FAIL abort%0d_none got %0d want 0", use_rst, rx_q.size() - base); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd0) $display("FAIL abort%0d_cnt0 got %0d want 0", use_rst, frame_cnt); else n_pass++;
    adc_start(); adc_bits(f2, 0, DW); tick(12);
    n_chk++; if (rx_q.size() - base !== 1) $display("FAIL abort%0d_count got %0d want 1", use_rst, rx_q.size() - base); else n_pass++;
    n_chk++; if (rx_at(base) !== f2) $display("FAIL abort%0d_frame got %h want %h", use_rst, rx_at(base), f2); else n_pass++;
    n_chk++; if (frame_cnt !== 16'd1) $display("FAIL abort%0d_cnt1 got %0d want 1", use_rst, frame_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_abort(1'b1);
    test_abort(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
